// File: rtl/gpio_serial_loader_pkg.sv
// ============================================================================
// gpio_loader_pkg : shared constants, FSM state type and index-width helper
//                   for the GPIO serial configuration loader.
// Revision        : 1.0
// ============================================================================
`default_nettype none

package gpio_loader_pkg;

   localparam int CFG_WORD_W = 13;
   localparam int BIT_CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_e;

   // A single-pad chain still needs a one-bit index port.
   function automatic int idx_width(input int num_pads);
      return (num_pads > 1) ? $clog2(num_pads) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_serial_loader_if.sv
// ============================================================================
// gpio_serial_loader_if : start/status handshake, register-file read port and
//                         serial chain outputs of the GPIO serial loader.
// Revision              : 1.0
// ============================================================================
`default_nettype none

interface gpio_serial_loader_if
   import gpio_loader_pkg::*;
#(
   parameter int NUM_PADS = 19
);

   localparam int IDX_W = idx_width(NUM_PADS);

   logic                  xfer_start;
   logic [IDX_W-1:0]      cfg_rd_idx;
   logic [CFG_WORD_W-1:0] cfg_rd_data;
   logic                  xfer_busy;
   logic                  xfer_done;
   logic                  serial_clock;
   logic                  serial_data;
   logic                  serial_load;

   // The loader itself.
   modport slave (
      input  xfer_start,
      input  cfg_rd_data,
      output cfg_rd_idx,
      output xfer_busy,
      output xfer_done,
      output serial_clock,
      output serial_data,
      output serial_load
   );

   // Housekeeping side: requests transfers and serves the register file.
   modport master (
      output xfer_start,
      output cfg_rd_data,
      input  cfg_rd_idx,
      input  xfer_busy,
      input  xfer_done,
      input  serial_clock,
      input  serial_data,
      input  serial_load
   );

endinterface

`default_nettype wire

// File: rtl/gpio_serial_loader_tick.sv
// ============================================================================
// gpio_loader_tick : CLK_DIV phase counter producing a phase-end pulse.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module gpio_loader_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic en,
   output logic phase_end
);

   localparam int              CNT_W   = $clog2(CLK_DIV + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      phase_end = en && (cnt_q == CNT_MAX);
      cnt_d     = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/gpio_serial_loader.sv
// ============================================================================
// gpio_serial_loader : streams per-pad GPIO config words MSB-first down the
//                      control-block chain, then pulses the load strobe.
// Optional macro     : GPIO_LOADER_AUTOLOAD_EN (one transfer per reset release)
// Revision           : 1.0
// ============================================================================
`default_nettype none

module gpio_serial_loader
   import gpio_loader_pkg::*;
#(
   parameter int NUM_PADS = 19,
   parameter int CLK_DIV  = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   gpio_serial_loader_if.slave  bus
);

   localparam int                    IDX_W    = idx_width(NUM_PADS);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_PADS - 1);
   localparam logic [BIT_CNT_W-1:0]  MSB_BIT  = BIT_CNT_W'(CFG_WORD_W - 1);

   state_e                state_q,        state_d;
   logic [CFG_WORD_W-1:0] shift_q,        shift_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q,      bit_cnt_d;
   logic [IDX_W-1:0]      cfg_rd_idx_q,   cfg_rd_idx_d;
   logic                  last_word_q,    last_word_d;
   logic                  serial_clock_q, serial_clock_d;
   logic                  serial_data_q,  serial_data_d;
   logic                  serial_load_q,  serial_load_d;
   logic                  xfer_busy_q,    xfer_busy_d;
   logic                  xfer_done_q,    xfer_done_d;

   logic                  start_req;
   logic                  phase_end;
   logic                  tick_clr;
   logic                  tick_en;

`ifdef GPIO_LOADER_AUTOLOAD_EN
   // Arm one cycle after release so the start lands in a clean IDLE cycle.
   logic autoload_arm_q,   autoload_arm_d;
   logic autoload_fired_q, autoload_fired_d;

   always_comb begin
      autoload_arm_d   = 1'b1;
      autoload_fired_d = autoload_fired_q | autoload_arm_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         autoload_arm_q   <= 1'b0;
         autoload_fired_q <= 1'b0;
      end else begin
         autoload_arm_q   <= autoload_arm_d;
         autoload_fired_q <= autoload_fired_d;
      end
   end

   assign start_req = bus.xfer_start | (autoload_arm_q & ~autoload_fired_q);
`else
   assign start_req = bus.xfer_start;
`endif

   assign tick_clr = (state_q == IDLE);
   assign tick_en  = (state_q == SHIFT) || (state_q == LOAD);

   gpio_loader_tick #(
      .CLK_DIV   (CLK_DIV)
   ) u_tick (
      .clk       (clk),
      .resetn    (resetn),
      .clr       (tick_clr),
      .en        (tick_en),
      .phase_end (phase_end)
   );

   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      cfg_rd_idx_d   = cfg_rd_idx_q;
      last_word_d    = last_word_q;
      serial_clock_d = serial_clock_q;
      serial_data_d  = serial_data_q;
      serial_load_d  = serial_load_q;
      xfer_busy_d    = xfer_busy_q;
      xfer_done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            cfg_rd_idx_d = LAST_IDX;
            if (start_req) begin
               shift_d        = bus.cfg_rd_data;
               bit_cnt_d      = MSB_BIT;
               last_word_d    = 1'b0;
               serial_data_d  = bus.cfg_rd_data[CFG_WORD_W-1];
               serial_clock_d = 1'b0;
               xfer_busy_d    = 1'b1;
               state_d        = SHIFT;
            end
         end

         SHIFT: begin
            if (phase_end) begin
               if (!serial_clock_q) begin
                  serial_clock_d = 1'b1;
               end else begin
                  serial_clock_d = 1'b0;
                  if (bit_cnt_q != '0) begin
                     shift_d       = {shift_q[CFG_WORD_W-2:0], shift_q[CFG_WORD_W-1]};
                     serial_data_d = shift_q[CFG_WORD_W-2];
                     bit_cnt_d     = bit_cnt_q - BIT_CNT_W'(1);
                     // Moving the index at bit 0 gives the register file a full bit period.
                     if (bit_cnt_q == BIT_CNT_W'(1)) begin
                        if (cfg_rd_idx_q == '0) begin
                           last_word_d = 1'b1;
                        end else begin
                           cfg_rd_idx_d = cfg_rd_idx_q - IDX_W'(1);
                        end
                     end
                  end else if (last_word_q) begin
                     serial_data_d = 1'b0;
                     serial_load_d = 1'b1;
                     state_d       = LOAD;
                  end else begin
                     shift_d       = bus.cfg_rd_data;
                     bit_cnt_d     = MSB_BIT;
                     serial_data_d = bus.cfg_rd_data[CFG_WORD_W-1];
                  end
               end
            end
         end

         LOAD: begin
            if (phase_end) begin
               serial_load_d = 1'b0;
               xfer_busy_d   = 1'b0;
               xfer_done_d   = 1'b1;
               cfg_rd_idx_d  = LAST_IDX;
               state_d       = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= IDLE;
         shift_q        <= '0;
         bit_cnt_q      <= '0;
         cfg_rd_idx_q   <= LAST_IDX;
         last_word_q    <= 1'b0;
         serial_clock_q <= 1'b0;
         serial_data_q  <= 1'b0;
         serial_load_q  <= 1'b0;
         xfer_busy_q    <= 1'b0;
         xfer_done_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         bit_cnt_q      <= bit_cnt_d;
         cfg_rd_idx_q   <= cfg_rd_idx_d;
         last_word_q    <= last_word_d;
         serial_clock_q <= serial_clock_d;
         serial_data_q  <= serial_data_d;
         serial_load_q  <= serial_load_d;
         xfer_busy_q    <= xfer_busy_d;
         xfer_done_q    <= xfer_done_d;
      end
   end

   assign bus.cfg_rd_idx   = cfg_rd_idx_q;
   assign bus.xfer_busy    = xfer_busy_q;
   assign bus.xfer_done    = xfer_done_q;
   assign bus.serial_clock = serial_clock_q;
   assign bus.serial_data  = serial_data_q;
   assign bus.serial_load  = serial_load_q;

endmodule

`default_nettype wire
